hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Central pipeline controller for the five-stage MIPS core; drives the stall, bubble and flush controls of the F/D, D/E, E/M and M/W pipeline registers, including their shared DEMWclr clear.
- Detects register read-after-write hazards from Tuse/Tnew.
- Tracks the multi-cycle mult/div unit with a busy counter.
- Sequences exception/eret flush-and-redirect through a small FSM.

Parameters:
- MULT_LAT, 5, cycles the HI/LO unit is busy after a mult/multu enters E.
- DIV_LAT, 10, cycles the HI/LO unit is busy after a div/divu enters E.
- RECOVER_CYC, 1, cycles after a flush during which new excM/eretM are ignored (range 1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rsD  in  5  rs field of the instruction in D.
- rtD  in  5  rt field of the instruction in D.
- tuse_rsD  in  2  cycles until D needs rs (0..2; 3 = not used).
- tuse_rtD  in  2  cycles until D needs rt (0..2; 3 = not used).
- waE  in  5  destination register in E (0 = none).
- tnewE  in  2  cycles until E result is available (0..2).
- waM  in  5  destination register in M (0 = none).
- tnewM  in  2  cycles until M result is available (0..1).
- mdD  in  1  D instruction uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- md_startE  in  1  a mult/div is in E this cycle.
- md_divE  in  1  qualifies md_startE: 1 = div, 0 = mult.
- excM  in  1  exception/interrupt taken at M.
- eretM  in  1  eret at M.
- stall  out  1  freeze PC and F/D register.
- clrE  out  1  load a bubble into D/E.
- DEMWclr  out  1  clear D/E, E/M, M/W (and F/D).
- pc_sel  out  2  0 = normal, 1 = exception vector 0x00004180, 2 = EPC.
- md_busy  out  1  HI/LO unit busy.
- md_start_ok  out  1  gated md_startE given to the mult/div unit.

Behaviour:
- Reset (rst=0, async): state=IDLE, md_cnt=0, rec_cnt=0. Outputs settle to stall=0, clrE=0, DEMWclr=0, pc_sel=0, md_busy=0, md_start_ok=0.
- RAW stall, computed separately for each source x in {rs, rt}:
  - stall_x = (xD!=0) && ((xD==waE && tuse_xD<tnewE) || (xD==waM && tuse_xD<tnewM)).
  - tuse=3 never stalls.
  - Register 0 never stalls.
- MD stall: stall_md = mdD && md_busy.
- md_busy = md_start_ok || (md_cnt!=0).
- md counter:
  - When md_start_ok=1: md_cnt <= (md_divE ? DIV_LAT : MULT_LAT) - 1.
  - Else if md_cnt!=0: md_cnt <= md_cnt-1.
  - Width is $clog2(DIV_LAT+1).
  - No wrap at 0.
  - A counter already running is never cancelled by a flush; its instruction is older than M.
- md_start_ok = md_startE && !flush_now.
- FSM states:
  - IDLE: flush_now = excM || eretM.
    - On flush_now: DEMWclr=1; pc_sel=1 if excM, else 2 (excM has priority when both are high); next state RECOVER, rec_cnt <= RECOVER_CYC-1.
  - RECOVER: excM/eretM ignored; DEMWclr=0; pc_sel=0.
    - If rec_cnt==0, go to IDLE; else decrement rec_cnt.
- Output priority, in the same cycle:
  - flush_now overrides everything: stall=0, clrE=0.
  - Otherwise stall = clrE = stall_rs || stall_rt || stall_md.
  - Stall and bubble are always asserted together.
- Latency: all stall/flush outputs are combinational from the current-cycle inputs plus state, so they take effect at the next clock edge of the pipeline registers.
- Async reset asserted mid-flush or mid-count returns to IDLE with md_cnt=0 immediately. The first cycle after deassertion behaves as IDLE.

Decomposition:
- Shared package/header constants:
  - PC_SEL_NORMAL/EXC/ERET.
  - EXC_VECTOR = 32'h0000_4180.
  - MULT_LAT and DIV_LAT defaults.
  - TUSE_NONE = 2'd3.
- One natural sub-module: md_busy_counter (counter plus md_busy/md_start_ok gating).
- RAW compare logic and FSM remain in the top module.

Test Plan:
- RAW on E (lw-use): rsD=8, tuse_rsD=0, waE=8, tnewE=2 -> stall=1, clrE=1. Next cycle with waE=0, waM=8, tnewM=1 -> stall=1; then tnewM=0 -> stall=0.
- Register 0 and no-use: rsD=0, waE=0, tnewE=2 -> stall=0. rtD=9, tuse_rtD=3, waE=9, tnewE=2 -> stall=0.
- Div busy: md_startE=1, md_divE=1 at cycle t -> md_busy=1 for cycles t..t+9, 0 at t+10. mdD=1 during that window -> stall=1; mdD=0 -> stall=0. Mult gives 5 cycles.
- Exception with simultaneous hazard: excM=1 while stall_rs conditions hold -> DEMWclr=1, pc_sel=1, stall=0, clrE=0. excM held high next cycle -> DEMWclr=0 (RECOVER).
- Priority and start suppression: excM=1, eretM=1, md_startE=1 in IDLE -> pc_sel=1, md_start_ok=0, md_cnt stays 0. Lone eretM later -> pc_sel=2.
- Async reset: drop rst mid-div (md_cnt=6) and in RECOVER -> md_busy=0 and state IDLE without a clock edge. After release, excM=1 -> DEMWclr=1 immediately.

Source files
------------

// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared constants, types and helpers for the pipeline hazard/flush controller.
package hazard_flush_ctrl_pkg;

  // PC source selection driven to the fetch stage.
  localparam logic [1:0] PC_SEL_NORMAL = 2'd0;
  localparam logic [1:0] PC_SEL_EXC    = 2'd1;
  localparam logic [1:0] PC_SEL_ERET   = 2'd2;

  // Exception handler entry point selected by PC_SEL_EXC.
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // Default HI/LO unit latencies and post-flush recovery window.
  localparam int MULT_LAT_DEF    = 5;
  localparam int DIV_LAT_DEF     = 10;
  localparam int RECOVER_CYC_DEF = 1;

  // Tuse encoding meaning "operand not read by this instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Flush sequencer states.
  typedef enum logic {
    ST_IDLE,
    ST_RECOVER
  } flush_state_t;

  // True when a source register read in D collides with an in-flight producer
  // in E or M whose result will not be ready before D needs it.
  function automatic logic raw_hit(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wa_e,
    input logic [1:0] tnew_e,
    input logic [4:0] wa_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == wa_e) && (tuse < tnew_e);
    hit_m = (src == wa_m) && (tuse < tnew_m);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_md_busy_counter.sv
// Busy tracker for the multi-cycle mult/div unit: counts down the remaining
// busy cycles and suppresses a start that coincides with a pipeline flush.
module md_busy_counter
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_startE,
  input  logic md_divE,
  input  logic flush_now,
  output logic md_busy,
  output logic md_start_ok
);

  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

  logic [CW-1:0] md_cnt;

  // A start squashed by a flush never reaches the unit; outputs stay quiet in reset.
  assign md_start_ok = rst && md_startE && !flush_now;
  assign md_busy     = md_start_ok || (md_cnt != '0);

  // Load the remaining busy cycles on a start, otherwise count down to zero and hold.
  // A running count is deliberately not cleared by a flush: its instruction is older than M.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      md_cnt <= '0;
    end else if (md_start_ok) begin
      md_cnt <= md_divE ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Central pipeline controller: RAW and HI/LO stalls, bubble insertion, and
// exception/eret flush-and-redirect sequencing for the five-stage core.
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int MULT_LAT    = MULT_LAT_DEF,
  parameter int DIV_LAT     = DIV_LAT_DEF,
  parameter int RECOVER_CYC = RECOVER_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] tuse_rsD,
  input  logic [1:0] tuse_rtD,
  input  logic [4:0] waE,
  input  logic [1:0] tnewE,
  input  logic [4:0] waM,
  input  logic [1:0] tnewM,
  input  logic       mdD,
  input  logic       md_startE,
  input  logic       md_divE,
  input  logic       excM,
  input  logic       eretM,
  output logic       stall,
  output logic       clrE,
  output logic       DEMWclr,
  output logic [1:0] pc_sel,
  output logic       md_busy,
  output logic       md_start_ok
);

  localparam logic [1:0] REC_LOAD = 2'(RECOVER_CYC - 1);

  flush_state_t state;
  logic [1:0]   rec_cnt;
  logic         flush_now;
  logic         stall_rs;
  logic         stall_rt;
  logic         stall_md;

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_counter (
    .clk         (clk),
    .rst         (rst),
    .md_startE   (md_startE),
    .md_divE     (md_divE),
    .flush_now   (flush_now),
    .md_busy     (md_busy),
    .md_start_ok (md_start_ok)
  );

  // A flush is accepted only outside the recovery window and never while in reset.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred.
    flush_now = 1'b0;
    if (rst && (state == ST_IDLE)) begin
      flush_now = excM || eretM;
    end
  end

  // Hazard detection and output priority: a flush overrides any stall request.
  always_comb begin
    stall_rs = raw_hit(rsD, tuse_rsD, waE, tnewE, waM, tnewM);
    stall_rt = raw_hit(rtD, tuse_rtD, waE, tnewE, waM, tnewM);
    stall_md = mdD && md_busy;

    DEMWclr = flush_now;
    pc_sel  = PC_SEL_NORMAL;
    if (flush_now) begin
      pc_sel = excM ? PC_SEL_EXC : PC_SEL_ERET;
    end

    stall = rst && !flush_now && (stall_rs || stall_rt || stall_md);
    clrE  = stall;
  end

  // Flush sequencer: after a redirect, ignore excM/eretM for RECOVER_CYC cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rec_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_now) begin
            state   <= ST_RECOVER;
            rec_cnt <= REC_LOAD;
          end
        end
        ST_RECOVER: begin
          if (rec_cnt == 2'd0) begin
            state <= ST_IDLE;
          end else begin
            rec_cnt <= rec_cnt - 2'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          rec_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-count based reference model.
module tb_hazard_flush_ctrl;
  import hazard_flush_ctrl_pkg::*;

  localparam int MULT_LAT    = 5;
  localparam int DIV_LAT     = 10;
  localparam int RECOVER_CYC = 1;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, waE, waM;
  logic [1:0] tuse_rsD, tuse_rtD, tnewE, tnewM;
  logic       mdD, md_startE, md_divE, excM, eretM;
  logic       stall, clrE, DEMWclr, md_busy, md_start_ok;
  logic [1:0] pc_sel;

  hazard_flush_ctrl #(
    .MULT_LAT    (MULT_LAT),
    .DIV_LAT     (DIV_LAT),
    .RECOVER_CYC (RECOVER_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rsD         (rsD),
    .rtD         (rtD),
    .tuse_rsD    (tuse_rsD),
    .tuse_rtD    (tuse_rtD),
    .waE         (waE),
    .tnewE       (tnewE),
    .waM         (waM),
    .tnewM       (tnewM),
    .mdD         (mdD),
    .md_startE   (md_startE),
    .md_divE     (md_divE),
    .excM        (excM),
    .eretM       (eretM),
    .stall       (stall),
    .clrE        (clrE),
    .DEMWclr     (DEMWclr),
    .pc_sel      (pc_sel),
    .md_busy     (md_busy),
    .md_start_ok (md_start_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: absolute cycle numbers rather than counters.
  int cyc          = 0;   // cycles since reset release
  int md_free      = 0;   // first cycle at which the HI/LO unit is idle
  int ignore_until = -1;  // last cycle in which excM/eretM are ignored

  logic       exp_flush, exp_start, exp_busy, exp_stall;
  logic [1:0] exp_pc;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A source stalls if any in-flight producer targets it and is too late.
  function automatic logic src_stalls(input logic [4:0] src, input logic [1:0] tuse);
    logic [4:0] wa[2];
    int         tn[2];
    wa[0] = waE; tn[0] = int'(tnewE);
    wa[1] = waM; tn[1] = int'(tnewM);
    if (src == 5'd0) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (src == wa[i] && int'(tuse) < tn[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    cyc          = 0;
    md_free      = 0;
    ignore_until = -1;
  endtask

  task automatic model_outputs();
    exp_flush = 1'b0; exp_start = 1'b0; exp_busy = 1'b0; exp_stall = 1'b0;
    exp_pc    = 2'd0;
    if (rst) begin
      exp_flush = (cyc > ignore_until) && (excM || eretM);
      exp_pc    = !exp_flush ? 2'd0 : (excM ? 2'd1 : 2'd2);
      exp_start = md_startE && !exp_flush;
      exp_busy  = exp_start || (cyc < md_free);
      exp_stall = !exp_flush &&
                  (src_stalls(rsD, tuse_rsD) || src_stalls(rtD, tuse_rtD) || (mdD && exp_busy));
    end
  endtask

  // Settle after input change (well before the next rising edge) and compare.
  task automatic eval(input string tag);
    #1;
    model_outputs();
    check({tag, ".stall"},       {1'b0, stall},       {1'b0, exp_stall});
    check({tag, ".clrE"},        {1'b0, clrE},        {1'b0, exp_stall});
    check({tag, ".DEMWclr"},     {1'b0, DEMWclr},     {1'b0, exp_flush});
    check({tag, ".pc_sel"},      pc_sel,              exp_pc);
    check({tag, ".md_busy"},     {1'b0, md_busy},     {1'b0, exp_busy});
    check({tag, ".md_start_ok"}, {1'b0, md_start_ok}, {1'b0, exp_start});
  endtask

  // Advance the model across the rising edge and return at the falling edge.
  task automatic adv();
    if (rst) begin
      if (exp_start) md_free = cyc + (md_divE ? DIV_LAT : MULT_LAT);
      if (exp_flush) ignore_until = cyc + RECOVER_CYC;
      cyc++;
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rsD = 5'd0; rtD = 5'd0; tuse_rsD = TUSE_NONE; tuse_rtD = TUSE_NONE;
    waE = 5'd0; tnewE = 2'd0; waM = 5'd0; tnewM = 2'd0;
    mdD = 1'b0; md_startE = 1'b0; md_divE = 1'b0; excM = 1'b0; eretM = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state.
    excM = 1'b1;
    eval("reset");
    check("reset.const_stall",   {1'b0, stall},   2'd0);
    check("reset.const_DEMWclr", {1'b0, DEMWclr}, 2'd0);
    check("reset.const_pc_sel",  pc_sel,          2'd0);
    adv();
    idle_inputs();
    rst = 1'b1;
    eval("post_reset"); adv();

    // lw-use on E, then on M, then resolved.
    rsD = 5'd8; tuse_rsD = 2'd0; waE = 5'd8; tnewE = 2'd2;
    eval("raw_e");
    check("raw_e.const_stall", {1'b0, stall}, 2'd1);
    check("raw_e.const_clrE",  {1'b0, clrE},  2'd1);
    adv();
    waE = 5'd0; waM = 5'd8; tnewM = 2'd1;
    eval("raw_m");
    check("raw_m.const_stall", {1'b0, stall}, 2'd1);
    adv();
    tnewM = 2'd0;
    eval("raw_m_ready");
    check("raw_m_ready.const_stall", {1'b0, stall}, 2'd0);
    adv();

    // Register 0 and unused operand never stall.
    idle_inputs();
    rsD = 5'd0; tuse_rsD = 2'd0; waE = 5'd0; tnewE = 2'd2;
    eval("reg0");
    check("reg0.const_stall", {1'b0, stall}, 2'd0);
    adv();
    rtD = 5'd9; tuse_rtD = TUSE_NONE; waE = 5'd9; tnewE = 2'd2;
    eval("tuse_none");
    check("tuse_none.const_stall", {1'b0, stall}, 2'd0);
    adv();

    // Div: busy for 10 cycles starting at the start cycle.
    idle_inputs();
    md_startE = 1'b1; md_divE = 1'b1;
    eval("div_start"); adv();
    md_startE = 1'b0;
    for (int i = 1; i < DIV_LAT; i++) begin
      mdD = i[0];
      eval("div_busy");
      check("div_busy.const_busy",  {1'b0, md_busy}, 2'd1);
      check("div_busy.const_stall", {1'b0, stall},   {1'b0, i[0]});
      adv();
    end
    mdD = 1'b1;
    eval("div_done");
    check("div_done.const_busy",  {1'b0, md_busy}, 2'd0);
    check("div_done.const_stall", {1'b0, stall},   2'd0);
    adv();

    // Mult: busy for 5 cycles.
    idle_inputs();
    md_startE = 1'b1;
    eval("mult_start"); adv();
    md_startE = 1'b0;
    for (int i = 1; i < MULT_LAT; i++) begin
      eval("mult_busy");
      check("mult_busy.const_busy", {1'b0, md_busy}, 2'd1);
      adv();
    end
    eval("mult_done");
    check("mult_done.const_busy", {1'b0, md_busy}, 2'd0);
    adv();

    // Exception overriding a simultaneous RAW hazard; held excM ignored next cycle.
    rsD = 5'd8; tuse_rsD = 2'd0; waE = 5'd8; tnewE = 2'd2; excM = 1'b1;
    eval("exc_hz");
    check("exc_hz.const_DEMWclr", {1'b0, DEMWclr}, 2'd1);
    check("exc_hz.const_pc_sel",  pc_sel,          2'd1);
    check("exc_hz.const_stall",   {1'b0, stall},   2'd0);
    adv();
    eval("exc_recover");
    check("exc_recover.const_DEMWclr", {1'b0, DEMWclr}, 2'd0);
    adv();
    idle_inputs();
    eval("exc_idle"); adv();

    // excM beats eretM, and the coincident mult/div start is squashed.
    excM = 1'b1; eretM = 1'b1; md_startE = 1'b1;
    eval("prio");
    check("prio.const_pc_sel",   pc_sel,              2'd1);
    check("prio.const_start_ok", {1'b0, md_start_ok}, 2'd0);
    adv();
    idle_inputs();
    eval("prio_after");
    check("prio_after.const_busy", {1'b0, md_busy}, 2'd0);
    adv();
    eretM = 1'b1;
    eval("eret");
    check("eret.const_pc_sel", pc_sel, 2'd2);
    adv();
    idle_inputs();
    eval("eret_idle"); adv();

    // Async reset in the middle of a div count.
    md_startE = 1'b1; md_divE = 1'b1;
    eval("rdiv_start"); adv();
    md_startE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eval("rdiv_run"); adv();
    end
    rst = 1'b0;
    model_reset();
    eval("rdiv_reset");
    check("rdiv_reset.const_busy", {1'b0, md_busy}, 2'd0);
    adv();
    rst = 1'b1;
    eval("rdiv_release"); adv();

    // Async reset while in RECOVER; after release excM is taken at once.
    excM = 1'b1;
    eval("rrec_flush"); adv();
    rst = 1'b0;
    model_reset();
    eval("rrec_reset");
    rst = 1'b1;
    eval("rrec_release");
    check("rrec_release.const_DEMWclr", {1'b0, DEMWclr}, 2'd1);
    check("rrec_release.const_pc_sel",  pc_sel,          2'd1);
    adv();
    idle_inputs();
    eval("rrec_idle"); adv();

    // Randomized traffic with narrow register ranges to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      tuse_rsD  = 2'($urandom_range(0, 3));
      tuse_rtD  = 2'($urandom_range(0, 3));
      waE       = 5'($urandom_range(0, 3));
      tnewE     = 2'($urandom_range(0, 2));
      waM       = 5'($urandom_range(0, 3));
      tnewM     = 2'($urandom_range(0, 1));
      mdD       = 1'($urandom_range(0, 1));
      md_startE = ($urandom_range(0, 5) == 0);
      md_divE   = 1'($urandom_range(0, 1));
      excM      = ($urandom_range(0, 11) == 0);
      eretM     = ($urandom_range(0, 11) == 0);
      rst       = ($urandom_range(0, 99) != 0);
      if (!rst) model_reset();
      eval("rand");
      adv();
    end
    rst = 1'b1;
    idle_inputs();
    eval("final"); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
